// File: rtl/multicycle_processor_if.sv
// Instruction-fetch bus between the processor (master) and instruction memory (slave).
// The word in instr_data is taken when instr_req and instr_valid are both high.
interface multicycle_processor_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 8
);
  logic [PC_WIDTH-1:0]    instr_addr;
  logic                   instr_req;
  logic [INSTR_WIDTH-1:0] instr_data;
  logic                   instr_valid;

  modport master (output instr_addr, output instr_req, input instr_data, input instr_valid);
  modport slave  (input instr_addr, input instr_req, output instr_data, output instr_valid);
endinterface

// File: rtl/multicycle_processor.sv
// Multi-cycle add/load/store/beq processor: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK FSM
// with a private register file and data memory.
module multicycle_processor #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 2,
  parameter int PC_WIDTH       = 8,
  parameter int DMEM_DEPTH     = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  multicycle_processor_if.master ibus,
  output logic [DATA_WIDTH-1:0] reg_write_data,
  output logic                  wb_valid,
  output logic [2:0]            state,
  output logic [15:0]           retired
);
  localparam int RAW         = REG_ADDR_WIDTH;
  localparam int INSTR_WIDTH = 2 + 3 * RAW;
  localparam int REG_COUNT   = 2 ** RAW;
  localparam int DMEM_AW     = $clog2(DMEM_DEPTH);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_BEQ   = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [DATA_WIDTH-1:0]  rwd_q, rwd_d;
  logic                   wb_q, wb_d;
  logic [15:0]            ret_q, ret_d;
  logic                   instr_req;

  logic [DATA_WIDTH-1:0]  rf_view   [REG_COUNT];
  logic [DATA_WIDTH-1:0]  dmem_view [DMEM_DEPTH];
  logic                   rf_we, dm_we;
  logic [RAW-1:0]         rf_waddr;
  logic [DATA_WIDTH-1:0]  rf_wdata;

  logic [1:0]             opcode;
  logic [RAW-1:0]         rs, rt, rd;
  logic [DATA_WIDTH-1:0]  imm_data;
  logic [PC_WIDTH-1:0]    imm_pc, pc_inc;
  logic [DMEM_AW-1:0]     dm_idx;

  assign opcode   = ir_q[INSTR_WIDTH-1 -: 2];
  assign rs       = ir_q[3*RAW-1 -: RAW];
  assign rt       = ir_q[2*RAW-1 -: RAW];
  assign rd       = ir_q[RAW-1:0];
  assign imm_data = DATA_WIDTH'($signed(rd));
  assign imm_pc   = PC_WIDTH'($signed(rd));
  assign pc_inc   = pc_q + PC_WIDTH'(1);
  assign dm_idx   = DMEM_AW'(alu_q);

  assign ibus.instr_addr = pc_q;
  assign ibus.instr_req  = instr_req;
  assign reg_write_data  = rwd_q;
  assign wb_valid        = wb_q;
  assign state           = state_q;
  assign retired         = ret_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    rwd_d     = rwd_q;
    wb_d      = 1'b0;
    ret_d     = ret_q;
    rf_we     = 1'b0;
    rf_waddr  = rd;
    rf_wdata  = alu_q;
    dm_we     = 1'b0;
    instr_req = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_req = 1'b1;
        if (ibus.instr_valid) begin
          ir_d    = ibus.instr_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_view[rs];
        b_d     = rf_view[rt];
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_d = a_q + ((opcode == OP_ADD) ? b_q : imm_data);
        case (opcode)
          OP_BEQ: begin
            pc_d    = (a_q == b_q) ? (pc_inc + imm_pc) : pc_inc;
            ret_d   = ret_q + 16'd1;
            state_d = S_FETCH;
          end
          OP_ADD:  state_d = S_WRITEBACK;
          default: state_d = S_MEMORY;
        endcase
      end
      S_MEMORY: begin
        if (opcode == OP_STORE) begin
          dm_we   = 1'b1;
          pc_d    = pc_inc;
          ret_d   = ret_q + 16'd1;
          state_d = S_FETCH;
        end else begin
          mdr_d   = dmem_view[dm_idx];
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        rf_we = 1'b1;
        if (opcode == OP_LOAD) begin
          rf_waddr = rt;
          rf_wdata = mdr_q;
        end
        rwd_d   = rf_wdata;
        wb_d    = 1'b1;
        pc_d    = pc_inc;
        ret_d   = ret_q + 16'd1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      rwd_q   <= '0;
      wb_q    <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      rwd_q   <= rwd_d;
      wb_q    <= wb_d;
      ret_q   <= ret_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_rf
      logic [DATA_WIDTH-1:0] word_q;
      always_ff @(posedge clock or posedge clear) begin
        if (clear)
          word_q <= '0;
        else if (rf_we && (rf_waddr == RAW'(gi)))
          word_q <= rf_wdata;
      end
      assign rf_view[gi] = word_q;
    end

    // Data memory comes out of reset holding its own index in every word.
    for (gi = 0; gi < DMEM_DEPTH; gi++) begin : g_dmem
      logic [DATA_WIDTH-1:0] word_q;
      always_ff @(posedge clock or posedge clear) begin
        if (clear)
          word_q <= DATA_WIDTH'(gi);
        else if (dm_we && (dm_idx == DMEM_AW'(gi)))
          word_q <= b_q;
      end
      assign dmem_view[gi] = word_q;
    end
  endgenerate
endmodule

// File: tb/tb_multicycle_processor.sv
// Directed bench for multicycle_processor: hand-encoded instructions with
// hand-computed register/PC/counter results.
module tb_multicycle_processor;
  logic        clock;
  logic        clear;
  logic [7:0]  reg_write_data;
  logic        wb_valid;
  logic [2:0]  state;
  logic [15:0] retired;

  int n_total;
  int n_bad;
  int cyc;
  int wbs;
  int k;
  int guard;
  logic [2:0] seen [0:31];

  multicycle_processor_if #(.PC_WIDTH(8), .INSTR_WIDTH(8)) bus ();

  multicycle_processor #(
    .DATA_WIDTH(8), .REG_ADDR_WIDTH(2), .PC_WIDTH(8), .DMEM_DEPTH(16)
  ) dut (
    .clock          (clock),
    .clear          (clear),
    .ibus           (bus.master),
    .reg_write_data (reg_write_data),
    .wb_valid       (wb_valid),
    .state          (state),
    .retired        (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one instruction in FETCH and clock until the FSM is back in FETCH.
  task automatic run_instr(input logic [7:0] ins, output int c, output int w);
    c = 0;
    w = 0;
    seen[0] = state;
    bus.instr_data  = ins;
    bus.instr_valid = 1'b1;
    do begin
      @(posedge clock);
      #1;
      bus.instr_valid = 1'b0;
      c++;
      if (c < 32) seen[c] = state;
      if (wb_valid) w++;
    end while (state != 3'd0 && c < 20);
    $display("instr %02h: cycles=%0d wb=%0d rwd=%02h pc=%02h retired=%0d",
             ins, c, w, reg_write_data, bus.instr_addr, retired);
  endtask

  task automatic step(input string tag, input logic [7:0] ins, input int e_cyc, input int e_wb,
                      input logic [7:0] e_rwd, input logic [7:0] e_pc, input logic [15:0] e_ret);
    run_instr(ins, cyc, wbs);
    check_val({tag, "_cycles"}, cyc, e_cyc);
    check_val({tag, "_wb"}, wbs, e_wb);
    check_val({tag, "_rwd"}, {24'd0, reg_write_data}, {24'd0, e_rwd});
    check_val({tag, "_pc"}, {24'd0, bus.instr_addr}, {24'd0, e_pc});
    check_val({tag, "_retired"}, {16'd0, retired}, {16'd0, e_ret});
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
  endtask

  logic [7:0] dbl_tab [0:6];
  logic [7:0] inc_tab [0:6];

  initial begin
    n_total = 0;
    n_bad   = 0;
    clear   = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 8'h00;
    dbl_tab = '{8'd2, 8'd6, 8'd14, 8'd30, 8'd62, 8'd126, 8'd254};
    inc_tab = '{8'd3, 8'd7, 8'd15, 8'd31, 8'd63, 8'd127, 8'd255};

    repeat (2) @(posedge clock);
    #1;
    check_val("rst_state", {29'd0, state}, 32'd0);
    check_val("rst_req", {31'd0, bus.instr_req}, 32'd1);
    check_val("rst_pc", {24'd0, bus.instr_addr}, 32'd0);
    check_val("rst_wb", {31'd0, wb_valid}, 32'd0);
    check_val("rst_rwd", {24'd0, reg_write_data}, 32'd0);
    check_val("rst_retired", {16'd0, retired}, 32'd0);
    clear = 1'b0;

    // load r1 = mem[r0+1]
    step("load1", 8'h45, 5, 1, 8'h01, 8'h01, 16'd1);
    for (int i = 0; i < 5; i++) check_val($sformatf("load1_seq%0d", i), {29'd0, seen[i]}, i);
    step("add", 8'h16, 4, 1, 8'h02, 8'h02, 16'd2);     // r2 = r1+r1
    step("store", 8'h98, 4, 0, 8'h02, 8'h03, 16'd3);   // mem[1] = r2
    step("load2", 8'h4D, 5, 1, 8'h02, 8'h04, 16'd4);   // r3 = mem[1]
    step("add0", 8'h00, 4, 1, 8'h00, 8'h05, 16'd5);    // r0 = r0+r0
    step("beq_self", 8'hC3, 3, 0, 8'h00, 8'h05, 16'd6);
    step("beq_self2", 8'hC3, 3, 0, 8'h00, 8'h05, 16'd7);
    step("beq_nt", 8'hC6, 3, 0, 8'h00, 8'h06, 16'd8);
    step("beq_fwd", 8'hC1, 3, 0, 8'h00, 8'h08, 16'd9);

    // Fetch stall: valid low for 3 cycles
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_val($sformatf("stall_state%0d", i), {29'd0, state}, 32'd0);
      check_val($sformatf("stall_req%0d", i), {31'd0, bus.instr_req}, 32'd1);
      check_val($sformatf("stall_pc%0d", i), {24'd0, bus.instr_addr}, 32'd8);
    end
    step("stall_load", 8'h45, 5, 1, 8'h02, 8'h09, 16'd10);
    check_val("stall_decode", {29'd0, seen[1]}, 32'd1);

    // Data wrap: build r2 = 0xFF then add 1
    pulse_clear();
    step("w_l1", 8'h45, 5, 1, 8'h01, 8'h01, 16'd1);
    step("w_l2", 8'h49, 5, 1, 8'h01, 8'h02, 16'd2);
    k = 2;
    for (int i = 0; i < 7; i++) begin
      k++;
      step($sformatf("w_dbl%0d", i), 8'h2A, 4, 1, dbl_tab[i], 8'(k), 16'(k));
      k++;
      step($sformatf("w_inc%0d", i), 8'h26, 4, 1, inc_tab[i], 8'(k), 16'(k));
    end
    step("w_wrap", 8'h26, 4, 1, 8'h00, 8'd17, 16'd17);

    // PC wrap at 0xFF
    guard = 0;
    while (bus.instr_addr != 8'hFF && guard < 400) begin
      run_instr(8'h00, cyc, wbs);
      guard++;
    end
    check_val("pc_ff", {24'd0, bus.instr_addr}, 32'hFF);
    check_val("pc_ff_ret", {16'd0, retired}, 32'd255);
    step("pc_wrap", 8'h00, 4, 1, 8'h00, 8'h00, 16'd256);

    // Asynchronous clear during MEMORY of a store
    pulse_clear();
    step("c_l1", 8'h45, 5, 1, 8'h01, 8'h01, 16'd1);
    step("c_add", 8'h16, 4, 1, 8'h02, 8'h02, 16'd2);
    bus.instr_data  = 8'h98;
    bus.instr_valid = 1'b1;
    guard = 0;
    do begin
      @(posedge clock);
      #1;
      bus.instr_valid = 1'b0;
      guard++;
    end while (state != 3'd3 && guard < 10);
    $display("store reached state=%0d after %0d cycles", state, guard);
    check_val("clr_mem_state", {29'd0, state}, 32'd3);
    #2;
    clear = 1'b1;
    #1;
    check_val("clr_state", {29'd0, state}, 32'd0);
    check_val("clr_pc", {24'd0, bus.instr_addr}, 32'd0);
    check_val("clr_retired", {16'd0, retired}, 32'd0);
    check_val("clr_rwd", {24'd0, reg_write_data}, 32'd0);
    @(posedge clock);
    #1;
    clear = 1'b0;
    step("clr_load", 8'h45, 5, 1, 8'h01, 8'h01, 16'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
